// File: rtl/traffic_gen_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : traffic_gen_package
// Brief   : Shared types for the traffic generator request scheduler.
//           Field widths follow the scheduler's default parameter values.
// Rev     : 1.0  initial release
// ============================================================================
package traffic_gen_package;

  localparam int unsigned TG_ADDR_WIDTH = 32;
  localparam int unsigned TG_CNT_WIDTH  = 16;
  localparam int unsigned TG_GAP_WIDTH  = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_RD = 3'd1,
    S_ISSUE_WR = 3'd2,
    S_GAP      = 3'd3,
    S_DONE     = 3'd4
  } sched_state_t;

  // Run configuration captured at start.
  typedef struct packed {
    logic [TG_CNT_WIDTH-1:0]  n_trans;
    logic [3:0]               rd_len;
    logic [3:0]               wr_len;
    logic [TG_ADDR_WIDTH-1:0] base_addr;
    logic [15:0]              stride;
    logic [TG_GAP_WIDTH-1:0]  gap;
  } ctrl_sched_t;

  // Status reported back to the control wrapper.
  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic [TG_CNT_WIDTH-1:0] issued_cnt;
  } flags_sched_t;

  // The issue state of the opposite stream.
  function automatic sched_state_t other_phase(input sched_state_t s);
    return (s == S_ISSUE_RD) ? S_ISSUE_WR : S_ISSUE_RD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_gen_gap_timer.sv
`default_nettype none
// ============================================================================
// Module  : traffic_gen_gap_timer
// Brief   : Down-counter timing the idle gap between consecutive requests.
//           expired_o is high during the last gap cycle (count == 1).
// Rev     : 1.0  initial release
// ============================================================================
module traffic_gen_gap_timer #(
  parameter int unsigned GAP_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [GAP_WIDTH-1:0] value_i,
  output logic                 expired_o
);

  logic [GAP_WIDTH-1:0] cnt_q;
  logic [GAP_WIDTH-1:0] cnt_d;

  // Load on request, otherwise count down to zero and rest there.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - GAP_WIDTH'(1);
    end
  end

  // Counter register with synchronous reset / soft clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == GAP_WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/traffic_gen_sched.sv
`default_nettype none
// ============================================================================
// Module  : traffic_gen_sched
// Brief   : Sequences a programmed number of read/write requests onto two
//           valid/ready streams with alternating phases, strided addresses
//           and an optional idle gap after every handshake.
// Rev     : 1.0  initial release
// ============================================================================
module traffic_gen_sched
  import traffic_gen_package::*;
#(
  parameter int unsigned ADDR_WIDTH = TG_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = TG_CNT_WIDTH,
  parameter int unsigned GAP_WIDTH  = TG_GAP_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  n_trans_i,
  input  logic [3:0]            rd_len_i,
  input  logic [3:0]            wr_len_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [15:0]           stride_i,
  input  logic [GAP_WIDTH-1:0]  gap_i,
  output logic                  r_req_valid_o,
  output logic [ADDR_WIDTH-1:0] r_req_addr_o,
  input  logic                  r_req_ready_i,
  output logic                  w_req_valid_o,
  output logic [ADDR_WIDTH-1:0] w_req_addr_o,
  input  logic                  w_req_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  issued_cnt_o
);

  sched_state_t          state_q, state_d;
  sched_state_t          resume_q, resume_d;   // issue state to enter after GAP
  sched_state_t          next_issue;
  ctrl_sched_t           cfg_q, cfg_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [3:0]            phase_q, phase_d;
  logic                  gap_load;
  logic                  gap_expired;
  logic                  hs;
  logic [3:0]            cur_len;
  logic [3:0]            oth_len;
  flags_sched_t          flags;

  traffic_gen_gap_timer #(
    .GAP_WIDTH (GAP_WIDTH)
  ) u_gap_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .load_i    (gap_load),
    .value_i   (cfg_q.gap),
    .expired_o (gap_expired)
  );

  // Handshake and phase-length selection for the stream currently issuing.
  always_comb begin
    hs      = ((state_q == S_ISSUE_RD) && r_req_ready_i) ||
              ((state_q == S_ISSUE_WR) && w_req_ready_i);
    cur_len = (state_q == S_ISSUE_WR) ? cfg_q.wr_len : cfg_q.rd_len;
    oth_len = (state_q == S_ISSUE_WR) ? cfg_q.rd_len : cfg_q.wr_len;
  end

  // Next-state logic: config capture, issue sequencing, phase switching, gap.
  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    cfg_d      = cfg_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    phase_d    = phase_q;
    gap_load   = 1'b0;
    next_issue = state_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cfg_d.n_trans   = n_trans_i;
          cfg_d.rd_len    = rd_len_i;
          cfg_d.wr_len    = wr_len_i;
          cfg_d.base_addr = base_addr_i;
          cfg_d.stride    = stride_i;
          cfg_d.gap       = gap_i;
          issued_d        = '0;
          phase_d         = '0;
          addr_d          = base_addr_i;
          if ((n_trans_i == '0) || ((rd_len_i == 4'd0) && (wr_len_i == 4'd0))) begin
            state_d = S_DONE;
          end else if (rd_len_i != 4'd0) begin
            state_d = S_ISSUE_RD;
          end else begin
            state_d = S_ISSUE_WR;
          end
        end
      end

      S_ISSUE_RD, S_ISSUE_WR: begin
        if (hs) begin
          issued_d = issued_q + CNT_WIDTH'(1);
          addr_d   = addr_q + ADDR_WIDTH'(cfg_q.stride);
          // End of phase: hop to the other stream unless it has no length.
          if ((phase_q + 4'd1) == cur_len) begin
            phase_d    = '0;
            next_issue = (oth_len != 4'd0) ? other_phase(state_q) : state_q;
          end else begin
            phase_d    = phase_q + 4'd1;
            next_issue = state_q;
          end
          if ((issued_q + CNT_WIDTH'(1)) == cfg_q.n_trans) begin
            state_d = S_DONE;
          end else if (cfg_q.gap != '0) begin
            state_d  = S_GAP;
            resume_d = next_issue;
            gap_load = 1'b1;
          end else begin
            state_d = next_issue;
          end
        end
      end

      S_GAP: begin
        if (gap_expired) begin
          state_d = resume_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; clear_i aborts exactly like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q  <= S_IDLE;
      resume_q <= S_ISSUE_RD;
      cfg_q    <= '0;
      addr_q   <= '0;
      issued_q <= '0;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
      issued_q <= issued_d;
      phase_q  <= phase_d;
    end
  end

  // Status flags decoded from registered state only.
  always_comb begin
    flags.busy       = (state_q != S_IDLE);
    flags.done       = (state_q == S_DONE);
    flags.issued_cnt = issued_q;
  end

  assign r_req_valid_o = (state_q == S_ISSUE_RD);
  assign w_req_valid_o = (state_q == S_ISSUE_WR);
  assign r_req_addr_o  = addr_q;
  assign w_req_addr_o  = addr_q;
  assign busy_o        = flags.busy;
  assign done_o        = flags.done;
  assign issued_cnt_o  = flags.issued_cnt;

endmodule
`default_nettype wire

// File: tb/tb_traffic_gen_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_traffic_gen_sched
// Brief   : Directed self-checking bench for traffic_gen_sched with a
//           request scoreboard fed from an independent sequence model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_traffic_gen_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] n_trans_i = '0;
  logic [3:0]  rd_len_i = '0;
  logic [3:0]  wr_len_i = '0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] stride_i = '0;
  logic [7:0]  gap_i = '0;
  logic        r_req_valid_o;
  logic [31:0] r_req_addr_o;
  logic        r_req_ready_i = 1'b1;
  logic        w_req_valid_o;
  logic [31:0] w_req_addr_o;
  logic        w_req_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic [15:0] issued_cnt_o;

  traffic_gen_sched dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .start_i       (start_i),
    .n_trans_i     (n_trans_i),
    .rd_len_i      (rd_len_i),
    .wr_len_i      (wr_len_i),
    .base_addr_i   (base_addr_i),
    .stride_i      (stride_i),
    .gap_i         (gap_i),
    .r_req_valid_o (r_req_valid_o),
    .r_req_addr_o  (r_req_addr_o),
    .r_req_ready_i (r_req_ready_i),
    .w_req_valid_o (w_req_valid_o),
    .w_req_addr_o  (w_req_addr_o),
    .w_req_ready_i (w_req_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .issued_cnt_o  (issued_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Expected handshakes: {is_write, address}
  logic [32:0] exp_q[$];
  int unsigned exp_gap = 0;
  int unsigned last_hs_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sequence of a run, built straight from the operation rules.
  task automatic push_run(input int n, input int rl, input int wl,
                          input logic [31:0] base, input logic [15:0] stride);
    logic        wr;
    logic [31:0] a;
    int          ph;
    wr = (rl == 0);
    a  = base;
    ph = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({wr, a});
      a  = a + {16'h0, stride};
      ph = ph + 1;
      if (ph == (wr ? wl : rl)) begin
        ph = 0;
        if ((wr ? rl : wl) != 0) wr = ~wr;
      end
    end
  endtask

  // Monitor: scoreboard pops, stall stability, gap length, stream exclusivity.
  logic        pend = 1'b0;
  int unsigned idle_run = 0;
  logic        stall_prev = 1'b0;
  logic        clr_prev = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk_i) begin
    logic        v, wr, rdy;
    logic [31:0] a;
    logic [32:0] e;
    v   = r_req_valid_o | w_req_valid_o;
    wr  = w_req_valid_o;
    a   = wr ? w_req_addr_o : r_req_addr_o;
    rdy = wr ? w_req_ready_i : r_req_ready_i;
    if (rst_ni) chk("one_valid", 64'(r_req_valid_o & w_req_valid_o), 64'd0);
    if (start_i) begin
      pend = 1'b0;
      stall_prev = 1'b0;
    end
    if (stall_prev && !clr_prev) begin
      chk("stall_valid", 64'(v), 64'd1);
      chk("stall_addr", {31'd0, wr, a}, {31'd0, prev_wr, prev_addr});
    end
    if (v && pend) begin
      chk("gap_len", 64'(idle_run), 64'(exp_gap));
      pend = 1'b0;
    end else if (!v && pend) begin
      idle_run++;
    end
    if (v && rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_hs", {31'd0, wr, a}, 64'h1_0000_0000_0);
      end else begin
        e = exp_q.pop_front();
        chk("hs_req", {31'd0, wr, a}, {31'd0, e});
      end
      pend = 1'b1;
      idle_run = 0;
      last_hs_cyc = cyc;
    end
    stall_prev = v && !rdy;
    prev_wr    = wr;
    prev_addr  = a;
    clr_prev   = clear_i;
  end

  task automatic pulse_start(input int n, input int rl, input int wl,
                             input logic [31:0] base, input logic [15:0] stride,
                             input int g);
    n_trans_i   = 16'(n);
    rd_len_i    = 4'(rl);
    wr_len_i    = 4'(wl);
    base_addr_i = base;
    stride_i    = stride;
    gap_i       = 8'(g);
    exp_gap     = g;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    // Config changes after start must not affect the run.
    base_addr_i = 32'hDEAD_BEEF;
    stride_i    = 16'h0BAD;
    gap_i       = 8'd9;
  endtask

  task automatic finish_run(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_done_timing"}, 64'(cyc), 64'(last_hs_cyc + 1));
    chk({tag, "_issued"}, 64'(issued_cnt_o), 64'(n));
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk_i);
    chk({tag, "_busy_low"}, 64'(busy_o), 64'd0);
    chk({tag, "_done_low"}, 64'(done_o), 64'd0);
    chk({tag, "_issued_hold"}, 64'(issued_cnt_o), 64'(n));
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_r_valid", 64'(r_req_valid_o), 64'd0);
    chk("rst_w_valid", 64'(w_req_valid_o), 64'd0);
    chk("rst_r_addr", 64'(r_req_addr_o), 64'd0);
    chk("rst_w_addr", 64'(w_req_addr_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_issued", 64'(issued_cnt_o), 64'd0);

    // Degenerate start: n_trans = 0
    pulse_start(0, 2, 2, 32'h40, 16'd4, 0);
    @(negedge clk_i);
    chk("zero_done", 64'(done_o), 64'd1);
    chk("zero_busy", 64'(busy_o), 64'd1);
    chk("zero_valid", 64'(r_req_valid_o | w_req_valid_o), 64'd0);
    @(negedge clk_i);
    chk("zero_done_low", 64'(done_o), 64'd0);
    chk("zero_busy_low", 64'(busy_o), 64'd0);
    chk("zero_issued", 64'(issued_cnt_o), 64'd0);

    // Pure read run
    push_run(5, 2, 0, 32'h100, 16'd4);
    pulse_start(5, 2, 0, 32'h100, 16'd4, 0);
    finish_run("rd_only", 5);

    // Alternation R R W W W R R
    push_run(7, 2, 3, 32'h400, 16'd4);
    pulse_start(7, 2, 3, 32'h400, 16'd4, 0);
    finish_run("alt", 7);

    // Gap plus backpressure on the first request
    r_req_ready_i = 1'b0;
    push_run(3, 2, 0, 32'h800, 16'h20);
    pulse_start(3, 2, 0, 32'h800, 16'h20, 3);
    repeat (3) @(posedge clk_i);
    #1 r_req_ready_i = 1'b1;
    finish_run("gap_bp", 3);

    // Address wrap
    push_run(2, 1, 1, 32'hFFFF_FFFC, 16'd8);
    pulse_start(2, 1, 1, 32'hFFFF_FFFC, 16'd8, 0);
    finish_run("wrap", 2);

    // Abort with clear during a stall
    r_req_ready_i = 1'b0;
    pulse_start(4, 1, 1, 32'h3000, 16'd4, 0);
    repeat (2) @(posedge clk_i);
    #1 clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    r_req_ready_i = 1'b1;
    @(negedge clk_i);
    chk("abort_valid", 64'(r_req_valid_o | w_req_valid_o), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_issued", 64'(issued_cnt_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 64'(done_o), 64'd0);
      @(negedge clk_i);
    end

    // Fresh run after abort: R W W with a one-cycle gap
    push_run(3, 1, 2, 32'h2000, 16'h10);
    pulse_start(3, 1, 2, 32'h2000, 16'h10, 1);
    finish_run("post_abort", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_gen_sched.md
# traffic_gen_sched

Request scheduler for the traffic generator. On a start pulse, it sequences a programmed number of transactions into two valid/ready request streams: a read stream feeding the read-request port and a write stream feeding the write-request port. Reads and writes alternate in configurable phase lengths, addresses step through a strided pattern, and a programmable idle gap separates consecutive requests. It sits between the control wrapper, which supplies configuration and receives status/events, and the streamer request inputs.

## Interface
- ADDR_WIDTH, 32, request address width
- CNT_WIDTH, 16, transaction counter width
- GAP_WIDTH, 8, inter-request gap counter width
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- clear_i  in  1  synchronous soft clear; same effect as reset
- start_i  in  1  start pulse; ignored unless in IDLE
- n_trans_i  in  CNT_WIDTH  total transactions to issue
- rd_len_i  in  4  reads per read phase
- wr_len_i  in  4  writes per write phase
- base_addr_i  in  ADDR_WIDTH  first address
- stride_i  in  16  unsigned address increment per transaction
- gap_i  in  GAP_WIDTH  idle cycles after each handshake
- r_req_valid_o  out  1  read request valid
- r_req_addr_o  out  ADDR_WIDTH  read request address
- r_req_ready_i  in  1  read request ready
- w_req_valid_o  out  1  write request valid
- w_req_addr_o  out  ADDR_WIDTH  write request address
- w_req_ready_i  in  1  write request ready
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- issued_cnt_o  out  CNT_WIDTH  handshakes completed in the current run

## Operation
- FSM states: IDLE, ISSUE_RD, ISSUE_WR, GAP, DONE.
- IDLE on start_i:
  - Latch all config inputs. Zero the counters. Load addr = base_addr_i.
  - If n_trans_i == 0 or rd_len_i == wr_len_i == 0, go to DONE.
  - Otherwise go to ISSUE_RD if rd_len_i != 0, else ISSUE_WR.
- ISSUE_RD / ISSUE_WR:
  - Assert the matching valid; its addr output equals addr.
  - On handshake: issued_cnt++, phase_cnt++, addr += zero-extended stride.
  - addr wraps modulo 2^ADDR_WIDTH.
- Next-phase rule after a handshake:
  - If phase_cnt reaches the current phase length, switch to the other phase if its length != 0, otherwise repeat the same phase.
  - phase_cnt resets on every phase entry.
- After a handshake:
  - If issued_cnt + 1 == n_trans, go to DONE.
  - Else if gap != 0, go to GAP, loading gap_cnt = gap.
  - Else go directly to the next issue state.
- GAP: decrement gap_cnt; when it reaches 1, go to the next issue state.
- DONE: done_o = 1 for one cycle, then IDLE. issued_cnt_o holds until the next start.
- Only one valid is high at any time, and never outside the ISSUE states.
- clear_i or reset mid-run: abort immediately. Valid drops on the next edge even without a handshake. State returns to IDLE, all counters to 0, no done pulse.
- Config inputs are sampled only at start; later changes have no effect on a run in progress.

## Timing
- Reset values: every output is 0, including both addr outputs.
- start_i sampled at edge t → first valid high after edge t, busy_o high from the same cycle.
- Valid/ready rules:
  - Once valid is high, valid and addr stay stable until ready.
  - ready while valid is low has no effect.
  - A handshake is valid && ready on a clock edge.
- Throughput: with gap = 0, one handshake per cycle, including across phase switches; there is no bubble.
- Gap: with gap = g, exactly g valid-low cycles between a handshake and the next valid.
- Completion: the last handshake at edge t → DONE at t+1 (done_o high); IDLE at t+2, busy_o low.
- Degenerate start (n_trans_i == 0): done_o high the cycle after start; no valid is ever asserted.
- All outputs are driven from registers or from the registered state; there is no combinational path from ready to valid.

## Structure
- traffic_gen_package holds:
  - sched_state_t enum;
  - ctrl_sched_t struct (n_trans, rd_len, wr_len, base_addr, stride, gap);
  - flags_sched_t struct (busy, done, issued_cnt).
- One sub-module, traffic_gen_gap_timer:
  - inputs: load, value, clear;
  - output: expired;
  - used by the GAP state.

## Test plan
- Reset and idle:
  - Stimulus: release reset with no start.
  - Required: all outputs 0; start_i with n_trans = 0 gives done_o one cycle later, busy for 1 cycle, no valids.
- Pure read run:
  - Stimulus: n_trans = 5, rd_len = 2, wr_len = 0, base = 0x100, stride = 4, gap = 0, ready tied high.
  - Required: 5 consecutive read handshakes at addresses 0x100..0x110; done_o one cycle after the last; issued_cnt_o = 5.
- Alternation:
  - Stimulus: n_trans = 7, rd_len = 2, wr_len = 3, gap = 0.
  - Required: sequence R R W W W R R, no bubbles, addresses contiguous across both streams.
- Gap plus backpressure:
  - Stimulus: gap = 3; hold r_req_ready_i low for 4 cycles on the first request.
  - Required: valid and addr stable during the stall; exactly 3 idle cycles between handshakes.
- Wrap and abort:
  - Stimulus: base = 0xFFFFFFFC, stride = 8.
  - Required: second address is 0x00000004.
  - Stimulus: assert clear_i mid-stall.
  - Required: valid low next cycle, IDLE, no done_o; a new start then behaves normally.
